rate_divider: RTL and testbench
===============================

Name: rate_divider

Overview:
- Parametrised successor to the single free-running divider bus.
- Provides NUM_CH independent channels. Each channel has a runtime-programmable divide ratio and emits a one-cycle tick enable plus a 50%-duty level signal, all in the clk domain.
- Downstream FSMs use tick as a clock enable instead of clocking off a counter bit.
- Keeps a legacy free-running counter output for LED/debug use.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 32, width of the divide value, the per-channel counter and free_cnt.
- CH_W, $clog2(NUM_CH) (minimum 1), width of the channel select field.

Ports:
- clk  input  1  system clock (50 MHz on board).
- reset_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  configuration write request.
- cfg_ready  output  1  block can accept a configuration write.
- cfg_ch  input  CH_W  target channel index.
- cfg_div  input  CNT_W  divide value D.
- cfg_en  input  1  enable (1) or disable (0) the target channel.
- cfg_err  output  1  sticky flag: a write to a non-existent channel was accepted.
- tick  output  NUM_CH  per-channel single-cycle enable pulse.
- level  output  NUM_CH  per-channel square wave; toggles on each tick.
- free_cnt  output  CNT_W  free-running counter, +1 every clk.

Behaviour:
- Reset (reset_n low, asynchronous): all channels disabled; div=0, cnt=0; tick=0, level=0; free_cnt=0; cfg_ready=1; cfg_err=0.
- free_cnt: increments every cycle; wraps from all-ones to 0; unaffected by configuration.
- Handshake:
  - A write is accepted on a rising edge where cfg_valid && cfg_ready.
  - cfg_ready drops to 0 for exactly the one cycle after acceptance, then returns to 1. Back-to-back writes are therefore at most one every 2 cycles.
  - cfg_* inputs are sampled only at the acceptance edge.
- Accepted write to channel c < NUM_CH, at edge E0:
  - div[c] <= cfg_div, en[c] <= cfg_en, cnt[c] <= 0, tick[c] <= 0, level[c] <= 0.
  - A write always wins over a terminal count on that channel in the same cycle: no tick is produced at that edge.
- Accepted write with cfg_ch >= NUM_CH: no channel changes; cfg_err <= 1 (sticky until reset). cfg_ready still follows the handshake rule.
- Effective divide Deff = max(D,1). D=0 behaves as D=1: tick every cycle, level toggles every cycle.
- Enabled channel, every edge:
  - If cnt == Deff-1: cnt <= 0, tick <= 1, level <= ~level.
  - Otherwise: cnt <= cnt+1, tick <= 0.
- Timing consequences:
  - tick period is Deff cycles; level period is 2·Deff cycles.
  - After an enable write at E0, the first tick is high in the cycle after edge E0+Deff.
- Disabled channel: cnt held at 0; tick=0; level frozen at 0 (cleared by the disabling write).
- Counter arithmetic is CNT_W wide with no overflow. cnt never exceeds Deff-1; D=all-ones gives period 2^CNT_W-1.
- Channels are fully independent. A write to one channel never perturbs another channel's cnt, tick or level.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-count: everything returns to reset values immediately. After release, channels stay disabled until reconfigured.

Decomposition:
- Package rate_div_pkg holds:
  - CLK_HZ = 50_000_000.
  - Default CNT_W.
  - Constants DIV_1HZ = 50_000_000 and DIV_1KHZ = 50_000 for common rates.
  - Function hz_to_div(hz) = CLK_HZ/hz.
- Sub-module rate_divider_ch (one channel) owns div, en, cnt, tick and level. Its inputs are load strobe, div and en. It is generated NUM_CH times.
- The top level owns the handshake, the address decode, cfg_err and free_cnt.

Test Plan:
- Reset, then idle 10 cycles -> tick=0, level=0, cfg_ready=1; free_cnt=10 at cycle 10.
- Write ch0 D=4 en=1 -> cfg_ready low for 1 cycle; tick[0] pulses at 4, 8, 12 cycles after accept; level[0] toggles with a period of 8 cycles.
- NUM_CH=4: write ch1 D=0 and ch2 D=3, then ch2 en=0 -> ch1 ticks every cycle; ch2 ticks every 3 cycles; after the disabling write, tick[2]=0 and level[2]=0 while ch1 continues unchanged.
- Rewrite ch0 D=2 on the same edge where cnt[0]=3 (terminal) -> no tick that edge; next tick 2 cycles later, then every 2 cycles.
- Write cfg_ch=5 with NUM_CH=4 -> cfg_err=1 and stays 1; all channels unchanged; reset_n low -> cfg_err=0.
- Enable ch3 with D=100, assert reset_n low mid-count, release -> all outputs 0 and no ticks until ch3 is reprogrammed.

Source files
------------

// File: rtl/rate_div_pkg.sv
// Shared constants, types and helpers for the multi-channel rate divider.
package rate_div_pkg;

    localparam int unsigned CLK_HZ    = 50_000_000;
    localparam int unsigned DEF_CNT_W = 32;
    localparam int unsigned DIV_1HZ   = 50_000_000;
    localparam int unsigned DIV_1KHZ  = 50_000;

    // Configuration handshake: one accepted write, then one busy cycle.
    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_BUSY = 1'b1
    } hs_state_t;

    // Divide value that yields a tick rate of hz from CLK_HZ; 0 for hz == 0.
    function automatic int unsigned hz_to_div(input int unsigned hz);
        if (hz == 0) begin
            return 0;
        end
        return CLK_HZ / hz;
    endfunction

endpackage

// File: rtl/rate_divider_ch.sv
// One divider channel: programmable ratio, single-cycle tick, 50% duty level.
module rate_divider_ch
    import rate_div_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    input  logic             load_en,
    output logic             tick,
    output logic             level
);

    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic             en;
    logic [CNT_W-1:0] last_c;

    // Terminal count is Deff-1 where Deff = max(div, 1).
    always_comb begin
        last_c = '0;
        if (div != '0) begin
            last_c = div - CNT_W'(1);
        end
    end

    // Load wins over terminal count; disabled channels sit at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div   <= '0;
            en    <= 1'b0;
            cnt   <= '0;
            tick  <= 1'b0;
            level <= 1'b0;
        end else if (load) begin
            div   <= load_div;
            en    <= load_en;
            cnt   <= '0;
            tick  <= 1'b0;
            level <= 1'b0;
        end else if (en) begin
            if (cnt == last_c) begin
                cnt   <= '0;
                tick  <= 1'b1;
                level <= ~level;
            end else begin
                cnt   <= cnt + CNT_W'(1);
                tick  <= 1'b0;
            end
        end else begin
            cnt  <= '0;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/rate_divider.sv
// Multi-channel rate divider: config handshake, channel decode, error flag, free counter.
module rate_divider
    import rate_div_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] level,
    output logic [CNT_W-1:0]  free_cnt
);

    hs_state_t         state;
    hs_state_t         state_nxt;
    logic              accept_c;
    logic              ch_valid_c;
    logic [NUM_CH-1:0] load_c;

    // Handshake next state: accept in idle, then spend one cycle busy.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        case (state)
            HS_IDLE: begin
                if (cfg_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = HS_BUSY;
                end
            end
            HS_BUSY: begin
                state_nxt = HS_IDLE;
            end
            default: begin
                state_nxt = HS_IDLE;
            end
        endcase
    end

    // Handshake state and registered ready flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HS_IDLE;
            cfg_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            cfg_ready <= (state_nxt == HS_IDLE);
        end
    end

    // Compare at 32 bits so a channel field wider than needed still detects out-of-range indices.
    always_comb begin
        ch_valid_c = (32'(cfg_ch) < NUM_CH);
        load_c     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load_c[i] = accept_c && ch_valid_c && (cfg_ch == CH_W'(i));
        end
    end

    // Sticky error for accepted writes to non-existent channels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err <= 1'b0;
        end else if (accept_c && !ch_valid_c) begin
            cfg_err <= 1'b1;
        end
    end

    // Legacy free-running counter, wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            free_cnt <= '0;
        end else begin
            free_cnt <= free_cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rate_divider_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .load     (load_c[g]),
            .load_div (cfg_div),
            .load_en  (cfg_en),
            .tick     (tick[g]),
            .level    (level[g])
        );
    end

endmodule

// File: tb/tb_rate_divider.sv
// Directed bench for rate_divider with a small per-channel tick/level model.
module tb_rate_divider;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned CH_W   = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic              cfg_en = 1'b0;
    logic              cfg_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] level;
    logic [CNT_W-1:0]  free_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc [NUM_CH];
    int deff [NUM_CH];
    bit en_m [NUM_CH];

    rate_divider #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .CH_W   (CH_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .level     (level),
        .free_cnt  (free_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            en_m[c] = 1'b0;
            deff[c] = 1;
            acc[c]  = 0;
        end
    endtask

    // Expected tick/level for every channel from its accept cycle and Deff.
    task automatic check_outputs(input string tag);
        logic [NUM_CH-1:0] t;
        logic [NUM_CH-1:0] l;
        int k;
        t = '0;
        l = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (en_m[c]) begin
                k = cyc - acc[c];
                t[c] = (k != 0) && ((k % deff[c]) == 0);
                l[c] = ((k / deff[c]) % 2) == 1;
            end
        end
        check({tag, "_tick"}, 64'(tick), 64'(t));
        check({tag, "_level"}, 64'(level), 64'(l));
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            check_outputs(tag);
        end
    endtask

    // Issue one write; returns at the negedge right after the accepting edge.
    task automatic cfg_write(input int ch, input int d, input bit en);
        int waited;
        waited = 0;
        while (!cfg_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", 64'(cfg_ready), 64'(1));
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(d);
        cfg_en    = en;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        if (ch < NUM_CH) begin
            deff[ch] = (d == 0) ? 1 : d;
            en_m[ch] = en;
            acc[ch]  = cyc;
        end
        check("ready_drop", 64'(cfg_ready), 64'(0));
        check_outputs("post_write");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_free_cnt", 64'(free_cnt), 64'(0));
        check("rst_ready", 64'(cfg_ready), 64'(1));
        check("rst_err", 64'(cfg_err), 64'(0));
        reset_n = 1'b1;

        // Idle after reset
        run(10, "idle");
        check("idle_free_cnt", 64'(free_cnt), 64'(10));
        check("idle_ready", 64'(cfg_ready), 64'(1));

        // ch0 D=4: ticks at 4, 8, 12 after accept, level period 8
        cfg_write(0, 4, 1);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            check_outputs("ch0_d4");
            check("ch0_d4_tick_hand", 64'(tick[0]), 64'(n == 4 || n == 8 || n == 12));
            check("ch0_d4_level_hand", 64'(level[0]), 64'((n >= 4 && n < 8) || n >= 12));
            if (n == 1) check("ready_back", 64'(cfg_ready), 64'(1));
        end

        // cnt[0] is 3 here, so the accepting edge is the terminal edge
        cfg_write(0, 2, 1);
        check("term_no_tick", 64'(tick[0]), 64'(0));
        check("term_level_clr", 64'(level[0]), 64'(0));
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            check_outputs("ch0_d2");
            check("ch0_d2_tick_hand", 64'(tick[0]), 64'((n % 2) == 0));
            check("ch0_d2_level_hand", 64'(level[0]), 64'(((n / 2) % 2) == 1));
        end

        // ch1 D=0 ticks every cycle, ch2 D=3, then ch2 disabled
        cfg_write(1, 0, 1);
        run(4, "ch1_d0");
        check("ch1_every_cycle", 64'(tick[1]), 64'(1));
        cfg_write(2, 3, 1);
        run(9, "ch2_d3");
        check("ch2_tick_9", 64'(tick[2]), 64'(1));
        cfg_write(2, 0, 0);
        check("ch2_off_tick", 64'(tick[2]), 64'(0));
        check("ch2_off_level", 64'(level[2]), 64'(0));
        run(6, "ch2_off");
        check("ch1_still_ticks", 64'(tick[1]), 64'(1));

        // Out-of-range channel sets sticky error, nothing else changes
        cfg_write(5, 7, 1);
        check("err_set", 64'(cfg_err), 64'(1));
        run(6, "bad_ch");
        cfg_write(3, 5, 1);
        run(10, "after_bad");
        check("err_sticky", 64'(cfg_err), 64'(1));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_clear();
        check("err_cleared", 64'(cfg_err), 64'(0));
        check("rst2_tick", 64'(tick), 64'(0));
        check("rst2_level", 64'(level), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // ch3 D=100, reset mid-count, stays silent until reprogrammed
        cfg_write(3, 100, 1);
        run(30, "ch3_d100");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        check("mid_rst_free_cnt", 64'(free_cnt), 64'(0));
        check("mid_rst_ready", 64'(cfg_ready), 64'(1));
        check("mid_rst_tick", 64'(tick), 64'(0));
        check("mid_rst_level", 64'(level), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        run(120, "post_reset");
        check("post_reset_quiet", 64'(tick), 64'(0));
        cfg_write(3, 3, 1);
        run(8, "ch3_reprog");
        check("ch3_reprog_level", 64'(level[3]), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
